jacobian_column_engine: RTL and testbench

- Parametrised, sequential successor to the fixed 6-joint Jacobian datapath.
- Builds the geometric Jacobian one column per joint: for revolute joints Jv = z × (s − o) and Jw = z; for prismatic joints Jv = z and Jw = 0.
- Joint frames (z, o) arrive on a valid/ready stream from the forward-kinematics T-block chain. Columns leave on a valid/ready stream toward the inverse-kinematics solver.
- Joint count, data width and fraction position are parameters, not hard-coded.

---
 rtl/jacobian_column_engine.sv | 209 ++++++++++++++++++++
 tb/tb_jacobian_column_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobian_column_engine.sv
// Sequential geometric-Jacobian column builder: one joint frame in, one 6-element column out.
// Revolute: Jv = z x (s - o), Jw = z. Prismatic: Jv = z, Jw = 0.
module jacobian_column_engine #(
    parameter int unsigned MAX_JOINTS = 6,
    parameter int unsigned WIDTH      = 27,
    parameter int unsigned FRAC       = 16,
    parameter int unsigned JW         = $clog2(MAX_JOINTS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [JW-1:0]        num_joints,
    input  logic [3*WIDTH-1:0]   s_in,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*WIDTH-1:0]   in_z,
    input  logic [3*WIDTH-1:0]   in_o,
    input  logic                 in_prismatic,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*WIDTH-1:0]   out_col,
    output logic [JW-1:0]        out_joint,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitJ,
        StDiff,
        StMul,
        StSub,
        StOut,
        StFin
    } state_e;

    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [JW-1:0]    MaxJ   = JW'(MAX_JOINTS);

    // Clamp a WIDTH+1 bit two's-complement value into WIDTH bits.
    function automatic logic [WIDTH-1:0] sat_narrow(input logic [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1]) begin
            return v[WIDTH] ? SatMin : SatMax;
        end
        return v[WIDTH-1:0];
    endfunction

    // Clamp a 2*WIDTH+1 bit value: in range only when all bits above WIDTH-1 match the sign.
    function automatic logic [WIDTH-1:0] sat_wide(input logic [2*WIDTH:0] v);
        logic [WIDTH+1:0] hi;
        hi = v[2*WIDTH:WIDTH-1];
        if ((&hi) || !(|hi)) begin
            return v[WIDTH-1:0];
        end
        return v[2*WIDTH] ? SatMin : SatMax;
    endfunction

    function automatic logic [WIDTH:0] sub_narrow(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return {a[WIDTH-1], a} - {b[WIDTH-1], b};
    endfunction

    // Signed product via sign-extended operands; the low 2*WIDTH bits are exact.
    function automatic logic [2*WIDTH-1:0] mul_s(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ae;
        logic [2*WIDTH-1:0] be;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic [WIDTH-1:0] cross_elem(input logic [2*WIDTH-1:0] p,
                                                    input logic [2*WIDTH-1:0] q);
        logic [2*WIDTH:0] diff;
        logic [2*WIDTH:0] shifted;
        diff    = {p[2*WIDTH-1], p} - {q[2*WIDTH-1], q};
        shifted = $signed(diff) >>> FRAC;
        return sat_wide(shifted);
    endfunction

    state_e                     state_q, state_d;
    logic [2:0][WIDTH-1:0]      s_q, s_d;
    logic [2:0][WIDTH-1:0]      z_q, z_d;
    logic [2:0][WIDTH-1:0]      o_q, o_d;
    logic [2:0][WIDTH-1:0]      d_q, d_d;
    logic [5:0][2*WIDTH-1:0]    prod_q, prod_d;
    logic                       prism_q, prism_d;
    logic [JW-1:0]              n_q, n_d;
    logic [JW-1:0]              cnt_q, cnt_d;
    logic [5:0][WIDTH-1:0]      col_q, col_d;
    logic [JW-1:0]              joint_q, joint_d;
    logic                       valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        z_d     = z_q;
        o_d     = o_q;
        d_d     = d_q;
        prod_d  = prod_q;
        prism_d = prism_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        joint_d = joint_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    s_d     = s_in;
                    n_d     = (num_joints > MaxJ) ? MaxJ : num_joints;
                    cnt_d   = '0;
                    state_d = (n_d == '0) ? StFin : StWaitJ;
                end
            end
            StWaitJ: begin
                if (in_valid) begin
                    z_d     = in_z;
                    o_d     = in_o;
                    prism_d = in_prismatic;
                    state_d = StDiff;
                end
            end
            StDiff: begin
                for (int i = 0; i < 3; i++) begin
                    d_d[i] = sat_narrow(sub_narrow(s_q[i], o_q[i]));
                end
                state_d = StMul;
            end
            StMul: begin
                prod_d[0] = mul_s(z_q[1], d_q[2]);
                prod_d[1] = mul_s(z_q[2], d_q[1]);
                prod_d[2] = mul_s(z_q[2], d_q[0]);
                prod_d[3] = mul_s(z_q[0], d_q[2]);
                prod_d[4] = mul_s(z_q[0], d_q[1]);
                prod_d[5] = mul_s(z_q[1], d_q[0]);
                state_d   = StSub;
            end
            StSub: begin
                if (prism_q) begin
                    col_d[2:0] = z_q;
                    col_d[5:3] = '0;
                end else begin
                    col_d[0]   = cross_elem(prod_q[0], prod_q[1]);
                    col_d[1]   = cross_elem(prod_q[2], prod_q[3]);
                    col_d[2]   = cross_elem(prod_q[4], prod_q[5]);
                    col_d[5:3] = z_q;
                end
                joint_d = cnt_q;
                valid_d = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + JW'(1);
                    state_d = (cnt_d == n_q) ? StFin : StWaitJ;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            z_q     <= '0;
            o_q     <= '0;
            d_q     <= '0;
            prod_q  <= '0;
            prism_q <= 1'b0;
            n_q     <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            joint_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            z_q     <= z_d;
            o_q     <= o_d;
            d_q     <= d_d;
            prod_q  <= prod_d;
            prism_q <= prism_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            joint_q <= joint_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q != StIdle) && (state_q != StFin);
    assign in_ready  = (state_q == StWaitJ);
    assign done      = (state_q == StFin);
    assign out_valid = valid_q;
    assign out_col   = col_q;
    assign out_joint = joint_q;

endmodule

// File: tb/tb_jacobian_column_engine.sv
// Directed and randomized bench for jacobian_column_engine against an integer reference model.
module tb_jacobian_column_engine;

    localparam int unsigned MJ = 6;
    localparam int unsigned W  = 27;
    localparam int unsigned FR = 16;
    localparam int unsigned JW = $clog2(MJ + 1);
    localparam int unsigned CW = 6 * W;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));
    localparam longint ONE  = longint'(1) << FR;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [JW-1:0]     num_joints = '0;
    logic [3*W-1:0]    s_in = '0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3*W-1:0]    in_z = '0;
    logic [3*W-1:0]    in_o = '0;
    logic              in_prismatic = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CW-1:0]     out_col;
    logic [JW-1:0]     out_joint;
    logic              done;

    jacobian_column_engine #(
        .MAX_JOINTS(MJ),
        .WIDTH     (W),
        .FRAC      (FR),
        .JW        (JW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_joints  (num_joints),
        .s_in        (s_in),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_z        (in_z),
        .in_o        (in_o),
        .in_prismatic(in_prismatic),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col     (out_col),
        .out_joint   (out_joint),
        .done        (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    logic [3*W-1:0] run_s;
    logic [3*W-1:0] fz[MJ];
    logic [3*W-1:0] fo[MJ];
    bit             fp[MJ];
    logic [CW-1:0]  last_col;

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic longint sx(input logic [W-1:0] e);
        return longint'($signed(e));
    endfunction

    function automatic logic [3*W-1:0] pack3(input longint x, input longint y, input longint z);
        return {W'(z), W'(y), W'(x)};
    endfunction

    // Reference: d = sat(s - o); Jv = sat(floor((z x d) / 2^FR)); Jw = z (revolute).
    function automatic logic [CW-1:0] model_col(input logic [3*W-1:0] s, input logic [3*W-1:0] z,
                                                input logic [3*W-1:0] o, input bit pr);
        longint zv[3];
        longint d[3];
        longint jv[3];
        for (int i = 0; i < 3; i++) begin
            zv[i] = sx(z[i*W +: W]);
            d[i]  = sat(sx(s[i*W +: W]) - sx(o[i*W +: W]));
        end
        if (pr) return {pack3(0, 0, 0), pack3(zv[0], zv[1], zv[2])};
        jv[0] = sat((zv[1] * d[2] - zv[2] * d[1]) >>> FR);
        jv[1] = sat((zv[2] * d[0] - zv[0] * d[2]) >>> FR);
        jv[2] = sat((zv[0] * d[1] - zv[1] * d[0]) >>> FR);
        return {pack3(zv[0], zv[1], zv[2]), pack3(jv[0], jv[1], jv[2])};
    endfunction

    task automatic check_col(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] relem();
        case ($urandom_range(0, 3))
            0:       return W'($urandom);
            1:       return W'(longint'($urandom_range(0, 8 * 65536)) - 4 * ONE);
            2:       return W'(longint'($urandom_range(0, 2 * 65536)) - ONE);
            default: return ($urandom_range(0, 1) == 0) ? W'(SMAX) : W'(SMIN);
        endcase
    endfunction

    task automatic rand_frames();
        run_s = {relem(), relem(), relem()};
        for (int i = 0; i < MJ; i++) begin
            fz[i] = {relem(), relem(), relem()};
            fo[i] = {relem(), relem(), relem()};
            fp[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Runs one start..done sequence; begins and ends at a negedge.
    task automatic run(input int n_req, input int stall_j, input int stall_n, input bit mid_start);
        int n;
        int d0;
        int g;
        int lat;
        logic [CW-1:0] exp;
        n  = (n_req > MJ) ? MJ : n_req;
        d0 = done_cnt;
        start      = 1'b1;
        num_joints = JW'(n_req);
        s_in       = run_s;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check_bit("done_n0", done, 1'b1);
            check_bit("busy_n0", busy, 1'b0);
            @(negedge clk);
            check_val("done_pulses_n0", done_cnt - d0, 1);
            return;
        end
        check_bit("busy_run", busy, 1'b1);
        for (int j = 0; j < n; j++) begin
            in_z         = fz[j];
            in_o         = fo[j];
            in_prismatic = fp[j];
            in_valid     = 1'b1;
            g = 0;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            check_bit("in_ready_wait", in_ready, 1'b1);
            if (!in_ready) begin
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
            if (mid_start && j == 1) begin
                start      = 1'b1;
                num_joints = JW'(2);
                s_in       = {relem(), relem(), relem()};
            end
            lat = 0;
            while (!out_valid && lat < 50) begin
                @(negedge clk);
                start = 1'b0;
                lat++;
            end
            start = 1'b0;
            check_val("latency", lat, 3);
            exp = model_col(run_s, fz[j], fo[j], fp[j]);
            last_col = out_col;
            check_col("col", out_col, exp);
            check_val("joint", longint'(out_joint), j);
            if (j == stall_j) begin
                repeat (stall_n) begin
                    @(negedge clk);
                    check_col("col_hold", out_col, exp);
                    check_bit("valid_hold", out_valid, 1'b1);
                    check_bit("in_ready_hold", in_ready, 1'b0);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (j < n - 1) check_bit("no_early_done", done, 1'b0);
        end
        check_bit("done_after_last", done, 1'b1);
        check_bit("busy_fin", busy, 1'b0);
        check_bit("valid_fin", out_valid, 1'b0);
        @(negedge clk);
        check_bit("done_one_cycle", done, 1'b0);
        check_val("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_col("rst_col", out_col, '0);
        check_val("rst_joint", longint'(out_joint), 0);

        // Single revolute joint: s=(2,0,0), z=(0,0,1), o=0
        run_s = pack3(2 * ONE, 0, 0);
        fz[0] = pack3(0, 0, ONE);
        fo[0] = '0;
        fp[0] = 1'b0;
        run(1, -1, 0, 1'b0);
        check_val("jvy_2p0", longint'(last_col[W +: W]), 64'h20000);

        // Prismatic joint
        fz[0] = pack3(0, ONE, 0);
        fo[0] = pack3(5 * ONE, 5 * ONE, 5 * ONE);
        fp[0] = 1'b1;
        run(1, -1, 0, 1'b0);
        check_col("prismatic_const", last_col, {pack3(0, 0, 0), pack3(0, ONE, 0)});

        // Difference saturation
        run_s = pack3(SMAX, 0, 0);
        fz[0] = pack3(0, 0, ONE);
        fo[0] = pack3(SMIN, 0, 0);
        fp[0] = 1'b0;
        run(1, -1, 0, 1'b0);
        check_val("jvy_dsat", sx(last_col[W +: W]), SMAX);

        // Product overflow clamps at both bounds
        run_s = pack3(SMAX, 0, 0);
        fz[0] = pack3(0, 0, SMAX);
        fo[0] = '0;
        run(1, -1, 0, 1'b0);
        check_val("jvy_psat_hi", sx(last_col[W +: W]), SMAX);
        run_s = pack3(SMIN, 0, 0);
        run(1, -1, 0, 1'b0);
        check_val("jvy_psat_lo", sx(last_col[W +: W]), SMIN);

        // Six joints with a 4-cycle stall on joint 2, and a start pulse mid-run
        rand_frames();
        run(6, 2, 4, 1'b1);

        // Boundaries: zero joints, and over-range joint count
        run(0, -1, 0, 1'b0);
        rand_frames();
        run(7, -1, 0, 1'b0);

        // Reset while in MUL
        rand_frames();
        start      = 1'b1;
        num_joints = JW'(2);
        s_in       = run_s;
        @(negedge clk);
        start    = 1'b0;
        in_z     = fz[0];
        in_o     = fo[0];
        in_valid = 1'b1;
        check_bit("mr_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        begin
            int d0;
            d0 = done_cnt;
            check_bit("mr_busy", busy, 1'b0);
            check_bit("mr_in_ready_0", in_ready, 1'b0);
            check_bit("mr_out_valid", out_valid, 1'b0);
            check_bit("mr_done", done, 1'b0);
            check_col("mr_col", out_col, '0);
            check_val("mr_joint", longint'(out_joint), 0);
            repeat (8) @(negedge clk);
            check_val("mr_no_done", done_cnt - d0, 0);
        end
        run(3, -1, 0, 1'b0);

        // Random runs
        for (int r = 0; r < 6; r++) begin
            rand_frames();
            run(int'($urandom_range(1, 7)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
